// File: rtl/cas_upload_server.sv
// cas_upload_server: buffers decoded cassette-write bytes and serves them to hps_io as an upload
module cas_upload_server #(
    parameter int ADDR_W = 16,
    parameter logic [7:0] PAD_BYTE = 8'h00
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              cap_en,
    input  logic              cap_valid,
    input  logic [7:0]        cap_data,
    input  logic              cap_clear,
    input  logic              ioctl_upload,
    input  logic              ioctl_rd,
    input  logic [ADDR_W-1:0] ioctl_addr,
    output logic [7:0]        ioctl_din,
    output logic              upload_req,
    output logic [ADDR_W:0]   cap_len,
    output logic              overflow,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, CAPTURE, UPLOAD} state_t;
    localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};
    state_t state, next;
    logic [7:0] ram [2**ADDR_W];
    logic req_r, full, clr, wr_en, drop, entry_clr, req_set, rd_en;
    // State register
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= next;
    end
    // Upload has top priority; otherwise the motor level alone picks capture vs idle
    always_comb begin
        next = ioctl_upload ? UPLOAD : cap_en ? CAPTURE : IDLE;
    end
    // Per-cycle control decoded from the current state and inputs
    always_comb begin
        busy = state != IDLE;
        full = cap_len == FULL;
        clr = cap_clear && state != UPLOAD;
        wr_en = state == CAPTURE && cap_valid && !clr && !full;
        drop = cap_valid && !clr && (state != CAPTURE || full);
        entry_clr = state == IDLE && next == CAPTURE && cap_len == '0;
        req_set = state == CAPTURE && next == IDLE && cap_len != '0;
        rd_en = state == UPLOAD && ioctl_rd;
        upload_req = req_r && !ioctl_upload;
    end
    // Length, sticky overflow, save request and upload read data
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            cap_len <= '0;
            overflow <= 1'b0;
            req_r <= 1'b0;
            ioctl_din <= 8'h00;
        end else begin
            req_r <= req_set;
            cap_len <= clr ? '0 : wr_en ? cap_len + 1'b1 : cap_len;
            overflow <= clr ? 1'b0 : drop ? 1'b1 : entry_clr ? 1'b0 : overflow;
            if (rd_en) ioctl_din <= ({1'b0, ioctl_addr} < cap_len) ? ram[ioctl_addr] : PAD_BYTE;
        end
    end
    // Capture write port
    always_ff @(posedge clk_sys) begin
        if (wr_en) ram[cap_len[ADDR_W-1:0]] <= cap_data;
    end
endmodule

// File: tb/tb_cas_upload_server.sv
// tb_cas_upload_server: directed self-checking bench for the cassette upload buffer
module tb_cas_upload_server;
    localparam int AW = 4;
    logic clk_sys = 1'b0;
    logic reset, cap_en, cap_valid, cap_clear, ioctl_upload, ioctl_rd;
    logic [7:0] cap_data, ioctl_din;
    logic [AW-1:0] ioctl_addr;
    logic upload_req, overflow, busy;
    logic [AW:0] cap_len;
    int tests = 0;
    int fails = 0;

    cas_upload_server #(.ADDR_W(AW), .PAD_BYTE(8'h00)) dut (
        .clk_sys(clk_sys), .reset(reset), .cap_en(cap_en), .cap_valid(cap_valid),
        .cap_data(cap_data), .cap_clear(cap_clear), .ioctl_upload(ioctl_upload),
        .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr), .ioctl_din(ioctl_din),
        .upload_req(upload_req), .cap_len(cap_len), .overflow(overflow), .busy(busy)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        cap_valid = 1'b1;
        cap_data = d;
        tick();
        cap_valid = 1'b0;
    endtask

    task automatic rd(input logic [AW-1:0] a);
        ioctl_rd = 1'b1;
        ioctl_addr = a;
        tick();
        ioctl_rd = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; cap_en = 0; cap_valid = 0; cap_data = 0; cap_clear = 0;
        ioctl_upload = 0; ioctl_rd = 0; ioctl_addr = 0;
        #12;
        tests++; if (ioctl_din !== 8'h00) begin fails++; $display("FAIL reset_din got %h want 00", ioctl_din); end
        tests++; if (upload_req !== 1'b0) begin fails++; $display("FAIL reset_req got %b want 0", upload_req); end
        tests++; if (cap_len !== 5'd0) begin fails++; $display("FAIL reset_len got %0d want 0", cap_len); end
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_ovf got %b want 0", overflow); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
        @(negedge clk_sys);
        reset = 1'b0;
        tick();
    endtask

    task automatic test_capture();
        int pulses = 0;
        cap_en = 1'b1;
        tick();
        push(8'h55); push(8'hAA); push(8'h3C);
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL cap_busy got %b want 1", busy); end
        cap_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (upload_req === 1'b1) pulses++;
        end
        tests++; if (pulses != 1) begin fails++; $display("FAIL cap_req_pulses got %0d want 1", pulses); end
        tests++; if (cap_len !== 5'd3) begin fails++; $display("FAIL cap_len got %0d want 3", cap_len); end
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL cap_ovf got %b want 0", overflow); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL cap_idle_busy got %b want 0", busy); end
    endtask

    task automatic test_upload();
        logic [7:0] exp [4];
        exp[0] = 8'h55; exp[1] = 8'hAA; exp[2] = 8'h3C; exp[3] = 8'h00;
        ioctl_upload = 1'b1;
        tick();
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL up_busy got %b want 1", busy); end
        for (int i = 0; i < 4; i++) begin
            rd(AW'(i));
            tests++; if (ioctl_din !== exp[i]) begin fails++; $display("FAIL up_rd%0d got %h want %h", i, ioctl_din, exp[i]); end
        end
        rd(4'd1);
        tick();
        tests++; if (ioctl_din !== 8'hAA) begin fails++; $display("FAIL up_hold got %h want aa", ioctl_din); end
        tests++; if (upload_req !== 1'b0) begin fails++; $display("FAIL up_req got %b want 0", upload_req); end
        ioctl_upload = 1'b0;
        tick();
        rd(4'd0);
        tests++; if (ioctl_din !== 8'hAA) begin fails++; $display("FAIL idle_rd got %h want aa", ioctl_din); end
        tests++; if (cap_len !== 5'd3) begin fails++; $display("FAIL up_len got %0d want 3", cap_len); end
        tests++; if (upload_req !== 1'b0) begin fails++; $display("FAIL up_exit_req got %b want 0", upload_req); end
    endtask

    task automatic test_overflow();
        cap_clear = 1'b1; tick(); cap_clear = 1'b0;
        tests++; if (cap_len !== 5'd0) begin fails++; $display("FAIL clr_len got %0d want 0", cap_len); end
        cap_en = 1'b1;
        tick();
        for (int i = 0; i < 17; i++) push(8'h10 + 8'(i));
        tests++; if (cap_len !== 5'd16) begin fails++; $display("FAIL ovf_len got %0d want 16", cap_len); end
        tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_flag got %b want 1", overflow); end
        cap_en = 1'b0; tick(); tick();
        ioctl_upload = 1'b1; tick();
        rd(4'd15);
        tests++; if (ioctl_din !== 8'h1F) begin fails++; $display("FAIL ovf_rd15 got %h want 1f", ioctl_din); end
        rd(4'd0);
        tests++; if (ioctl_din !== 8'h10) begin fails++; $display("FAIL ovf_rd0 got %h want 10", ioctl_din); end
        ioctl_upload = 1'b0; tick();
    endtask

    task automatic test_idle();
        int pulses = 0;
        cap_clear = 1'b1; tick(); cap_clear = 1'b0;
        cap_en = 1'b1; tick(); cap_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (upload_req === 1'b1) pulses++;
        end
        tests++; if (pulses != 0) begin fails++; $display("FAIL empty_req got %0d want 0", pulses); end
        push(8'h99);
        tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL idle_ovf got %b want 1", overflow); end
        tests++; if (cap_len !== 5'd0) begin fails++; $display("FAIL idle_len got %0d want 0", cap_len); end
    endtask

    task automatic test_clear();
        cap_clear = 1'b1; tick(); cap_clear = 1'b0;
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL clr_ovf got %b want 0", overflow); end
        cap_en = 1'b1; tick();
        for (int i = 0; i < 5; i++) push(8'h40 + 8'(i));
        tests++; if (cap_len !== 5'd5) begin fails++; $display("FAIL clr_pre_len got %0d want 5", cap_len); end
        cap_clear = 1'b1;
        push(8'hEE);
        cap_clear = 1'b0;
        tests++; if (cap_len !== 5'd0) begin fails++; $display("FAIL clr_win_len got %0d want 0", cap_len); end
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL clr_win_ovf got %b want 0", overflow); end
        push(8'h77);
        tests++; if (cap_len !== 5'd1) begin fails++; $display("FAIL clr_after_len got %0d want 1", cap_len); end
    endtask

    task automatic test_reset_mid();
        #2 reset = 1'b1;
        #1;
        tests++; if (busy !== 1'b0 || cap_len !== 5'd0) begin fails++; $display("FAIL rst_cap got busy=%b len=%0d want 0/0", busy, cap_len); end
        cap_en = 1'b0;
        @(negedge clk_sys); reset = 1'b0;
        tick();
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_cap_idle got %b want 0", busy); end
        cap_en = 1'b1; tick(); push(8'h77); cap_en = 1'b0; tick();
        ioctl_upload = 1'b1; tick();
        rd(4'd0);
        tests++; if (ioctl_din !== 8'h77) begin fails++; $display("FAIL rst_pre_rd got %h want 77", ioctl_din); end
        #2 reset = 1'b1;
        #1;
        tests++; if (ioctl_din !== 8'h00 || busy !== 1'b0 || cap_len !== 5'd0 || upload_req !== 1'b0 || overflow !== 1'b0)
            begin fails++; $display("FAIL rst_up got din=%h busy=%b len=%0d req=%b ovf=%b want all 0", ioctl_din, busy, cap_len, upload_req, overflow); end
        ioctl_upload = 1'b0;
        @(negedge clk_sys); reset = 1'b0;
        tick();
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_up_idle got %b want 0", busy); end
    endtask

    initial begin
        test_reset();
        test_capture();
        test_upload();
        test_overflow();
        test_idle();
        test_clear();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
